// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci-class sequence generator:
// run-state encoding, default sizes and the saturation fill value.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  localparam int FIB_WIDTH_DEF = 32;
  localparam int FIB_CNT_W_DEF = 8;

  // Replicated across the term width to form the all-ones saturated term
  localparam logic FIB_SAT_BIT = 1'b1;

endpackage

// File: rtl/fib_step.sv
// One recurrence step: a+b evaluated one bit wider so the carry is visible.
// Build option FIB_SAT_EN: when defined, an overflowing sum is clamped to
// all-ones; otherwise the truncated sum is passed through and the carry
// alone tells the controller to stop the run.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] fullSum;

  // Widened add, carry extraction and the optional clamp
  always_comb begin
    fullSum = {1'b0, a_i} + {1'b0, b_i};
    carry_o = fullSum[WIDTH];
`ifdef FIB_SAT_EN
    sum_o   = carry_o ? {WIDTH{FIB_SAT_BIT}} : fullSum[WIDTH-1:0];
`else
    sum_o   = fullSum[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Parametrised Fibonacci-class sequence generator with loadable seeds,
// programmable term count, valid/ready output and overflow reporting.
// Build option FIB_SAT_EN: when defined, overflowing terms saturate to
// all-ones and the run continues; when undefined, the run ends in DONE
// after the last representable term has been transferred.
//
// Datapath invariant: a_q is always the presented term and b_q the term
// that follows it; bOvf_q remembers that b_q came from an overflowing add.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int CNT_W = FIB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] term_out,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] nTerms_q, nTerms_d;
  logic             bOvf_q, bOvf_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] stepSum;
  logic             stepCarry;
  logic             startOk;
  logic             xfer;
  logic             lastXfer;
  logic             ovfStop;

  fib_step #(.WIDTH(WIDTH)) uStep (
    .a_i    (a_q),
    .b_i    (b_q),
    .sum_o  (stepSum),
    .carry_o(stepCarry)
  );

  // Handshake decode: start acceptance, transfers, last term and overflow stop
  always_comb begin
    startOk  = start && (state_q != RUN);
    xfer     = (state_q == RUN) && ready;
    lastXfer = xfer && (idx_q == nTerms_q - 1'b1);
`ifdef FIB_SAT_EN
    ovfStop  = 1'b0;
`else
    ovfStop  = xfer && !lastXfer && bOvf_q;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (n_terms != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (lastXfer || ovfStop) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    valid = (state_q == RUN);
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
  end

  // Datapath next values: load seeds on start, advance on non-final transfers
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    nTerms_d = nTerms_q;
    bOvf_d   = bOvf_q;
    ovf_d    = ovf_q;
    if (startOk) begin
      a_d      = seed0;
      b_d      = seed1;
      idx_d    = '0;
      nTerms_d = n_terms;
      bOvf_d   = 1'b0;
      ovf_d    = 1'b0;
    end else if (ovfStop) begin
      ovf_d    = 1'b1;
    end else if (xfer && !lastXfer) begin
      a_d      = b_q;
      b_d      = stepSum;
      idx_d    = idx_q + 1'b1;
      bOvf_d   = stepCarry;
      ovf_d    = ovf_q | bOvf_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      nTerms_q <= '0;
      bOvf_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      nTerms_q <= nTerms_d;
      bOvf_q   <= bOvf_d;
      ovf_q    <= ovf_d;
    end
  end

  assign term_out = a_q;
  assign term_idx = idx_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: a 32-bit and an 8-bit instance share control
// inputs; transferred terms are collected and compared with a reference
// sequence computed from the recurrence with plain 64-bit arithmetic.
module tb_fib_seq_gen;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [CW-1:0] nTerms;
  logic [31:0]   s0w, s1w;
  logic [7:0]    s0n, s1n;

  logic          v32, b32, d32, o32;
  logic [31:0]   t32;
  logic [CW-1:0] i32;
  logic          v8, b8, d8, o8;
  logic [7:0]    t8;
  logic [CW-1:0] i8;

  int vecs = 0;
  int errs = 0;

  longint unsigned got32[$], got8[$], exp32[$], exp8[$], expQ[$];
  int idxErr32, idxErr8, hold32, hold8, cyc, doneCyc32, doneCyc8;
  bit fin32, fin8, expOvf32, expOvf8;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(32), .CNT_W(CW)) dut32 (
    .clk(clk), .rst(rst), .start(start), .seed0(s0w), .seed1(s1w),
    .n_terms(nTerms), .ready(ready), .valid(v32), .term_out(t32),
    .term_idx(i32), .busy(b32), .done(d32), .ovf(o32)
  );

  fib_seq_gen #(.WIDTH(8), .CNT_W(CW)) dut8 (
    .clk(clk), .rst(rst), .start(start), .seed0(s0n), .seed1(s1n),
    .n_terms(nTerms), .ready(ready), .valid(v8), .term_out(t8),
    .term_idx(i8), .busy(b8), .done(d8), .ovf(o8)
  );

  // Reference: the emitted sequence for w-bit terms, returns expected ovf
  function automatic bit model(input int w, input longint unsigned a,
                               input longint unsigned b, input int n);
    longint unsigned maxv = (64'd1 << w) - 1;
    longint unsigned t;
    bit ov = 1'b0;
    expQ.delete();
    for (int k = 0; k < n; k++) begin
      if (k == 0) t = a;
      else if (k == 1) t = b;
      else begin
        t = expQ[k-2] + expQ[k-1];
        if (t > maxv) begin
          ov = 1'b1;
`ifdef FIB_SAT_EN
          t = maxv;
`else
          break;
`endif
        end
      end
      expQ.push_back(t);
    end
    return ov;
  endfunction

  // Pulse start for one clock; returns at the negedge after acceptance
  task automatic do_start(input int n, input logic [31:0] a32, input logic [31:0] bb32,
                          input logic [7:0] a8, input logic [7:0] bb8);
    @(negedge clk);
    s0w = a32; s1w = bb32; s0n = a8; s1n = bb8;
    nTerms = n[CW-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive ready (0: always, 1: 1,0,0 pattern, 2: random) and record transfers
  task automatic capture(input int mode, input int injectAt);
    logic [31:0] prev32;
    logic [7:0]  prev8;
    bit held32 = 1'b0, held8 = 1'b0;
    got32.delete(); got8.delete();
    idxErr32 = 0; idxErr8 = 0; hold32 = 0; hold8 = 0;
    fin32 = 1'b0; fin8 = 1'b0; cyc = 0; doneCyc32 = -1; doneCyc8 = -1;
    while (!(fin32 && fin8) && cyc < 2000) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      start = (cyc == injectAt);
      if (start) begin
        s0w = $urandom; s1w = $urandom; s0n = 8'($urandom); s1n = 8'($urandom);
        nTerms = CW'($urandom_range(1, 200));
      end
      if (v32) begin
        if (held32 && t32 !== prev32) hold32++;
        if (ready) begin
          got32.push_back(t32);
          if (int'(i32) != got32.size() - 1) idxErr32++;
          held32 = 1'b0;
        end else begin
          held32 = 1'b1; prev32 = t32;
        end
      end else begin
        if (held32) hold32++;
        held32 = 1'b0;
        if (d32 && !fin32) begin fin32 = 1'b1; doneCyc32 = cyc; end
      end
      if (v8) begin
        if (held8 && t8 !== prev8) hold8++;
        if (ready) begin
          got8.push_back(t8);
          if (int'(i8) != got8.size() - 1) idxErr8++;
          held8 = 1'b0;
        end else begin
          held8 = 1'b1; prev8 = t8;
        end
      end else begin
        if (held8) hold8++;
        held8 = 1'b0;
        if (d8 && !fin8) begin fin8 = 1'b1; doneCyc8 = cyc; end
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  // Asynchronous reset forces every output to zero without a clock edge
  task automatic test_reset;
    rst = 1'b0; start = 1'b0; ready = 1'b0; nTerms = '0;
    s0w = '0; s1w = '0; s0n = '0; s1n = '0;
    #1;
    vecs++;
    if ({v32, b32, d32, o32, t32, i32} !== '0) begin
      errs++; $display("[TB] FAIL reset32 got %h want 0", {v32, b32, d32, o32, t32, i32});
    end
    vecs++;
    if ({v8, b8, d8, o8, t8, i8} !== '0) begin
      errs++; $display("[TB] FAIL reset8 got %h want 0", {v8, b8, d8, o8, t8, i8});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({v32, b32, d32, v8, b8, d8} !== 6'b0) begin
      errs++; $display("[TB] FAIL idle_after_reset got %b want 000000", {v32, b32, d32, v8, b8, d8});
    end
  endtask

  // Seeds 0/1, ten terms, ready held high
  task automatic test_basic;
    expOvf32 = model(32, 0, 1, 10);
    exp32 = expQ;
    do_start(10, 0, 1, 0, 1);
    capture(0, -1);
    vecs++;
    if (got32.size() != exp32.size()) begin
      errs++; $display("[TB] FAIL basic_count got %0d want %0d", got32.size(), exp32.size());
    end
    foreach (exp32[k]) if (k < got32.size()) begin
      vecs++;
      if (got32[k] !== exp32[k]) begin
        errs++; $display("[TB] FAIL basic_term[%0d] got %0d want %0d", k, got32[k], exp32[k]);
      end
    end
    vecs++;
    if (idxErr32 != 0) begin errs++; $display("[TB] FAIL basic_idx got %0d bad indices want 0", idxErr32); end
    vecs++;
    if (doneCyc32 != 10) begin errs++; $display("[TB] FAIL basic_latency got done at %0d want 10", doneCyc32); end
    vecs++;
    if ({d32, v32, b32, o32} !== {1'b1, 1'b0, 1'b0, expOvf32}) begin
      errs++; $display("[TB] FAIL basic_end got %b want %b", {d32, v32, b32, o32}, {1'b1, 1'b0, 1'b0, expOvf32});
    end
  endtask

  // Lucas seeds under a 1,0,0 ready pattern: terms held, never duplicated or skipped
  task automatic test_lucas_backpressure;
    expOvf32 = model(32, 2, 1, 6);
    exp32 = expQ;
    do_start(6, 2, 1, 2, 1);
    capture(1, -1);
    vecs++;
    if (got32.size() != exp32.size()) begin
      errs++; $display("[TB] FAIL lucas_count got %0d want %0d", got32.size(), exp32.size());
    end
    foreach (exp32[k]) if (k < got32.size()) begin
      vecs++;
      if (got32[k] !== exp32[k]) begin
        errs++; $display("[TB] FAIL lucas_term[%0d] got %0d want %0d", k, got32[k], exp32[k]);
      end
    end
    vecs++;
    if (hold32 != 0 || hold8 != 0) begin
      errs++; $display("[TB] FAIL lucas_hold got %0d/%0d unstable cycles want 0", hold32, hold8);
    end
    vecs++;
    if (idxErr32 != 0) begin errs++; $display("[TB] FAIL lucas_idx got %0d bad indices want 0", idxErr32); end
  endtask

  // 8-bit run past 233: stop or saturate depending on the build
  task automatic test_overflow;
    expOvf8 = model(8, 0, 1, 20);
    exp8 = expQ;
    do_start(20, 0, 1, 0, 1);
    capture(0, -1);
    vecs++;
    if (got8.size() != exp8.size()) begin
      errs++; $display("[TB] FAIL ovf_count got %0d want %0d", got8.size(), exp8.size());
    end
    foreach (exp8[k]) if (k < got8.size()) begin
      vecs++;
      if (got8[k] !== exp8[k]) begin
        errs++; $display("[TB] FAIL ovf_term[%0d] got %0d want %0d", k, got8[k], exp8[k]);
      end
    end
    vecs++;
    if ({d8, v8, b8, o8} !== {1'b1, 1'b0, 1'b0, expOvf8}) begin
      errs++; $display("[TB] FAIL ovf_end8 got %b want %b", {d8, v8, b8, o8}, {1'b1, 1'b0, 1'b0, expOvf8});
    end
    vecs++;
    if (got32.size() != 20 || o32 !== 1'b0) begin
      errs++; $display("[TB] FAIL ovf_wide got %0d terms ovf %b want 20 terms ovf 0", got32.size(), o32);
    end
    vecs++;
    if (idxErr8 != 0) begin errs++; $display("[TB] FAIL ovf_idx got %0d bad indices want 0", idxErr8); end
  endtask

  // n_terms 0 and 1, and a start pulse in the middle of a run
  task automatic test_edge_counts;
    logic [31:0] r0, r1;
    do_start(0, 32'd7, 32'd9, 8'd7, 8'd9);
    vecs++;
    if ({d32, v32, b32, o32} !== 4'b1000) begin
      errs++; $display("[TB] FAIL n0_state got %b want 1000", {d32, v32, b32, o32});
    end
    repeat (3) @(negedge clk);
    vecs++;
    if ({v32, v8, d32, d8} !== 4'b0011) begin
      errs++; $display("[TB] FAIL n0_hold got %b want 0011", {v32, v8, d32, d8});
    end
    r0 = $urandom;
    do_start(1, r0, 32'd5, r0[7:0], 8'd5);
    capture(2, -1);
    vecs++;
    if (got32.size() != 1 || got32[0] !== longint'(r0)) begin
      errs++; $display("[TB] FAIL n1_term got %0d terms first %0d want 1 term %0d",
                       got32.size(), (got32.size() > 0) ? got32[0] : 0, r0);
    end
    r0 = $urandom_range(0, 1000);
    r1 = $urandom_range(0, 1000);
    expOvf32 = model(32, r0, r1, 9);
    exp32 = expQ;
    do_start(9, r0, r1, r0[7:0], r1[7:0]);
    capture(2, 2);
    vecs++;
    if (got32.size() != exp32.size()) begin
      errs++; $display("[TB] FAIL midstart_count got %0d want %0d", got32.size(), exp32.size());
    end
    foreach (exp32[k]) if (k < got32.size()) begin
      vecs++;
      if (got32[k] !== exp32[k]) begin
        errs++; $display("[TB] FAIL midstart_term[%0d] got %0d want %0d", k, got32[k], exp32[k]);
      end
    end
  endtask

  // Reset dropped mid-run clears everything at once; a fresh run restarts at term 0
  task automatic test_async_reset;
    int guard;
    guard = 0;
    ready = 1'b1;
    do_start(10, 0, 1, 0, 1);
    while (i32 != CW'(4) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    vecs++;
    if (guard >= 50) begin errs++; $display("[TB] FAIL arst_reach_idx4 got idx %0d want 4", i32); end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({v32, b32, d32, o32, t32, i32, v8, b8, d8, o8, t8, i8} !== '0) begin
      errs++; $display("[TB] FAIL arst_clear got %h want 0", {v32, b32, d32, o32, t32, i32});
    end
    rst = 1'b1;
    ready = 1'b0;
    do_start(3, 0, 1, 0, 1);
    capture(0, -1);
    vecs++;
    if (got32.size() != 3 || got32[0] !== 0 || got32[1] !== 1 || got32[2] !== 1) begin
      errs++; $display("[TB] FAIL arst_restart got %0d terms want 0,1,1", got32.size());
    end
  endtask

  // Random seeds, counts and ready patterns on both widths
  task automatic test_random;
    int n, mode;
    logic [31:0] a32, bb32;
    logic [7:0]  a8, bb8;
    for (int it = 0; it < 8; it++) begin
      n    = $urandom_range(0, 40);
      mode = $urandom_range(0, 2);
      if (it % 2 == 0) begin
        a32 = $urandom_range(0, 20); bb32 = $urandom_range(0, 20);
      end else begin
        a32 = $urandom; bb32 = $urandom;
      end
      a8 = 8'($urandom_range(0, 30)); bb8 = 8'($urandom);
      expOvf32 = model(32, a32, bb32, n);
      exp32 = expQ;
      expOvf8 = model(8, a8, bb8, n);
      exp8 = expQ;
      do_start(n, a32, bb32, a8, bb8);
      capture(mode, -1);
      vecs++;
      if (got32.size() != exp32.size() || got8.size() != exp8.size()) begin
        errs++; $display("[TB] FAIL rand%0d_count got %0d/%0d want %0d/%0d",
                         it, got32.size(), got8.size(), exp32.size(), exp8.size());
      end
      foreach (exp32[k]) if (k < got32.size()) begin
        vecs++;
        if (got32[k] !== exp32[k]) begin
          errs++; $display("[TB] FAIL rand%0d_term32[%0d] got %0d want %0d", it, k, got32[k], exp32[k]);
        end
      end
      foreach (exp8[k]) if (k < got8.size()) begin
        vecs++;
        if (got8[k] !== exp8[k]) begin
          errs++; $display("[TB] FAIL rand%0d_term8[%0d] got %0d want %0d", it, k, got8[k], exp8[k]);
        end
      end
      vecs++;
      if ({d32, o32, d8, o8} !== {1'b1, expOvf32, 1'b1, expOvf8}) begin
        errs++; $display("[TB] FAIL rand%0d_end got %b want %b", it, {d32, o32, d8, o8},
                         {1'b1, expOvf32, 1'b1, expOvf8});
      end
      vecs++;
      if (hold32 + hold8 + idxErr32 + idxErr8 != 0) begin
        errs++; $display("[TB] FAIL rand%0d_hold_idx got %0d faults want 0", it,
                         hold32 + hold8 + idxErr32 + idxErr8);
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset;
    test_basic;
    test_lucas_backpressure;
    test_overflow;
    test_edge_counts;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
